// File: rtl/muldiv_if.sv
// Controller <-> mult/div sequencer handshake bundle.
// The master is the main controller; the slave is muldiv_seq.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             flush;
  logic             rd_req;
  logic             busy;
  logic             done;
  logic             hi_write;
  logic             lo_write;
  logic [WIDTH-1:0] out_hi;
  logic [WIDTH-1:0] out_lo;
  logic             stall;

  modport master (
    output start, op, operand_a, operand_b, flush, rd_req,
    input  busy, done, hi_write, lo_write, out_hi, out_lo, stall
  );

  modport slave (
    input  start, op, operand_a, operand_b, flush, rd_req,
    output busy, done, hi_write, lo_write, out_hi, out_lo, stall
  );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle MIPS MULT/MULTU/DIV/DIVU sequencer feeding HI/LO.
// Shift-add multiplier and restoring divider share one accumulator pair
// (acc_hi:acc_lo) and retire one bit per clock over WIDTH iterations.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] out_hi_r;
  logic [WIDTH-1:0] out_lo_r;

  // Working datapath: acc_lo holds multiplier / dividend-then-quotient,
  // acc_hi holds partial product high half / partial remainder.
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] dvs;
  logic             div_r;
  logic             neg_res;
  logic             neg_rem;

  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] x,
                                                  input logic neg);
    return neg ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] x,
                                                     input logic neg);
    return neg ? -x : x;
  endfunction

  logic                    sgn_op;
  logic                    a_neg;
  logic                    b_neg;
  logic [WIDTH-1:0]        a_mag;
  logic [WIDTH-1:0]        b_mag;
  logic                    div_zero;
  logic                    accept;
  logic [WIDTH:0]          mul_sum;
  logic [WIDTH:0]          div_shift;
  logic [WIDTH+1:0]        div_diff;
  logic                    div_ge;
  logic [WIDTH-1:0]        nxt_hi;
  logic [WIDTH-1:0]        nxt_lo;
  logic [2*WIDTH-1:0]      prod;
  logic [WIDTH-1:0]        res_hi;
  logic [WIDTH-1:0]        res_lo;

  // Operand decode, one iteration step, and final sign fix-up
  always_comb begin
    sgn_op   = ~bus.op[0];
    a_neg    = sgn_op & bus.operand_a[WIDTH-1];
    b_neg    = sgn_op & bus.operand_b[WIDTH-1];
    a_mag    = cond_neg_w(bus.operand_a, a_neg);
    b_mag    = cond_neg_w(bus.operand_b, b_neg);
    div_zero = bus.op[1] & (bus.operand_b == '0);
    accept   = bus.start & ~bus.flush & (state != RUN);

    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, dvs} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, dvs};
    div_ge    = ~div_diff[WIDTH+1];

    if (div_r) begin
      nxt_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], div_ge};
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end

    prod = cond_neg_2w({nxt_hi, nxt_lo}, neg_res);
    if (div_r) begin
      res_hi = cond_neg_w(nxt_hi, neg_rem);
      res_lo = cond_neg_w(nxt_lo, neg_res);
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  // Control FSM with registered status and HI/LO result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      out_hi_r <= '0;
      out_lo_r <= '0;
    end else if (bus.flush) begin
      state  <= IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (cnt == '0) begin
            state    <= DONE;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            out_hi_r <= res_hi;
            out_lo_r <= res_lo;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          done_r <= 1'b0;
          state  <= IDLE;
          if (bus.start) begin
            if (div_zero) begin
              state    <= DONE;
              done_r   <= 1'b1;
              out_hi_r <= bus.operand_a;
              out_lo_r <= '1;
            end else begin
              state  <= RUN;
              busy_r <= 1'b1;
              cnt    <= CNT_W'(WIDTH - 1);
            end
          end
        end
      endcase
    end
  end

  // Datapath registers: load magnitudes on accept, then iterate while running
  always_ff @(posedge clk) begin
    if (accept && !div_zero) begin
      acc_hi  <= '0;
      acc_lo  <= bus.op[1] ? a_mag : b_mag;
      dvs     <= bus.op[1] ? b_mag : a_mag;
      div_r   <= bus.op[1];
      neg_res <= a_neg ^ b_neg;
      neg_rem <= a_neg;
    end else if (state == RUN) begin
      acc_hi <= nxt_hi;
      acc_lo <= nxt_lo;
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.hi_write = done_r;
  assign bus.lo_write = done_r;
  assign bus.out_hi   = out_hi_r;
  assign bus.out_lo   = out_lo_r;
  assign bus.stall    = busy_r & (bus.start | bus.rd_req);

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus pushes expected {hi,lo},
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [63:0] sb[$];

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      chk("strobes", {62'd0, bus.hi_write, bus.lo_write}, 64'd3);
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got hi=0x%0h lo=0x%0h expected no completion",
                 bus.out_hi, bus.out_lo);
      end else begin
        chk("result", {bus.out_hi, bus.out_lo}, sb.pop_front());
      end
    end
  end

  // Present one request in the current cycle; accepted at the next posedge
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [63:0] exp);
    bus.start     = 1'b1;
    bus.op        = op;
    bus.operand_a = a;
    bus.operand_b = b;
    if (push) sb.push_back(exp);
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Count cycles from the accept edge until done; returns in the DONE cycle
  task automatic wait_done(input string name, input int lat0, input int exp_lat,
                           input int exp_busy);
    int lat = lat0;
    int bc  = 0;
    bit ok  = 1'b0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (bus.busy) bc++;
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got no done within %0d cycles expected done at %0d",
               name, lat, exp_lat);
    end else begin
      chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
      if (exp_busy >= 0) chk({name, "_busy_cycles"}, 64'(bc), 64'(exp_busy));
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.op        = 2'b00;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.flush     = 1'b0;
    bus.rd_req    = 1'b0;
    rst_n         = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_ctrl", {59'd0, bus.busy, bus.done, bus.hi_write, bus.lo_write, bus.stall}, 64'd0);
    chk("reset_out", {bus.out_hi, bus.out_lo}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Multiply
    @(negedge clk);
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 64'hFFFFFFFE_00000001);
    wait_done("multu_max", 0, 33, 32);
    @(negedge clk);
    issue(2'b00, 32'hFFFFFFFD, 32'd7, 1, 64'hFFFFFFFF_FFFFFFEB);
    wait_done("mult_neg", 0, 33, 32);
    @(negedge clk);
    issue(2'b00, 32'h80000000, 32'h80000000, 1, 64'h40000000_00000000);
    wait_done("mult_min", 0, 33, 32);

    // Divide
    @(negedge clk);
    issue(2'b11, 32'd100, 32'd7, 1, {32'd2, 32'd14});
    wait_done("divu_100_7", 0, 33, 32);
    @(negedge clk);
    issue(2'b10, 32'hFFFFFFF9, 32'd2, 1, 64'hFFFFFFFF_FFFFFFFD);
    wait_done("div_m7_2", 0, 33, 32);
    @(negedge clk);
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 1, 64'h00000000_80000000);
    wait_done("div_ovf", 0, 33, 32);
    @(negedge clk);
    issue(2'b11, 32'hFFFFFFFF, 32'h10, 1, 64'h0000000F_0FFFFFFF);
    wait_done("divu_big", 0, 33, 32);

    // Divide by zero: one-cycle latency, never busy
    @(negedge clk);
    issue(2'b11, 32'd5, 32'd0, 1, 64'h00000005_FFFFFFFF);
    wait_done("divu_zero", 0, 1, 0);
    @(negedge clk);
    issue(2'b10, 32'hFFFFFFF9, 32'd0, 1, 64'hFFFFFFF9_FFFFFFFF);
    wait_done("div_zero", 0, 1, 0);

    // start during RUN stalls and is ignored
    @(negedge clk);
    issue(2'b00, 32'hFFFFFFFD, 32'd7, 1, 64'hFFFFFFFF_FFFFFFEB);
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.operand_a = 32'd5; bus.operand_b = 32'd6;
    #1 chk("stall_on_start", {63'd0, bus.stall}, 64'd1);
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    wait_done("start_ignored", 5, 33, -1);

    // rd_req during RUN stalls until DONE
    @(negedge clk);
    issue(2'b11, 32'd100, 32'd7, 1, {32'd2, 32'd14});
    bus.rd_req = 1'b1;
    @(negedge clk);
    chk("stall_on_rd", {63'd0, bus.stall}, 64'd1);
    wait_done("rd_wait", 1, 33, -1);
    chk("stall_in_done", {62'd0, bus.stall, bus.busy}, 64'd0);
    bus.rd_req = 1'b0;

    // Back-to-back start in the DONE cycle
    @(negedge clk);
    issue(2'b01, 32'd3, 32'd5, 1, {32'd0, 32'd15});
    wait_done("b2b_first", 0, 33, 32);
    issue(2'b01, 32'h12345678, 32'h10, 1, 64'h00000001_23456780);
    wait_done("b2b_second", 0, 33, 32);

    // flush mid-RUN: no completion, outputs keep the last result
    @(negedge clk);
    issue(2'b01, 32'd7, 32'd7, 0, 64'd0);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", {63'd0, bus.busy}, 64'd0);
    chk("flush_hold", {bus.out_hi, bus.out_lo}, 64'h00000001_23456780);
    repeat (40) @(negedge clk);
    chk("flush_idle", {63'd0, bus.busy}, 64'd0);

    // flush in IDLE drops a simultaneous start
    @(negedge clk);
    bus.flush = 1'b1;
    issue(2'b11, 32'd9, 32'd0, 0, 64'd0);
    bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("flush_idle_drop", {bus.out_hi, bus.out_lo}, 64'h00000001_23456780);

    // Asynchronous reset mid-operation
    @(negedge clk);
    issue(2'b01, 32'd9, 32'd9, 0, 64'd0);
    repeat (5) @(negedge clk);
    bus.rd_req = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ctrl", {60'd0, bus.busy, bus.done, bus.hi_write, bus.stall}, 64'd0);
    chk("rst_mid_out", {bus.out_hi, bus.out_lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.rd_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_idle", {62'd0, bus.busy, bus.done}, 64'd0);
    issue(2'b10, 32'd7, 32'hFFFFFFFE, 1, 64'h00000001_FFFFFFFD);
    wait_done("after_reset", 0, 33, 32);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
